// File: rtl/sram_port_responder_if.sv
// Genie external data port bundle: write/read request handshakes plus the sticky protocol error flag.
// The master modport is the Genie side; the slave modport is the memory responder.
interface sram_port_responder_if #(
    parameter int AW = 26,
    parameter int DW = 32
);
    logic          wvalid;
    logic          wready;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          proto_err;

    modport master (
        output wvalid, waddr, wdata, rvalid, raddr,
        input  wready, rready, rdata, proto_err
    );

    modport slave (
        input  wvalid, waddr, wdata, rvalid, raddr,
        output wready, rready, rdata, proto_err
    );
endinterface

// File: rtl/sram_port_responder.sv
// Latency-programmable SRAM stand-in answering Genie's held write/read requests with one-cycle ready pulses.
// Optional SRAM_STALL_INJECT_EN adds LFSR-driven random extra wait cycles to both channels.
module sram_port_responder #(
    parameter int            AW         = 26,
    parameter int            DW         = 32,
    parameter int            DEPTH_LOG2 = 16,
    parameter int            WR_LAT     = 2,
    parameter int            RD_LAT     = 3,
    parameter logic [DW-1:0] OOR_DATA   = 32'hDEADBEEF
) (
    input logic                  clk,
    input logic                  rst,
    sram_port_responder_if.slave bus
);
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          w_state_q, w_state_d, r_state_q, r_state_d;
    logic [CW-1:0]   w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
    logic [AW-1:0]   waddr_q, raddr_q;
    logic [DW-1:0]   wdata_q;
    logic            wready_q, rready_q, proto_err_q;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            w_cap, w_commit, w_perr;
    logic            r_cap, r_commit, r_perr;
    logic            stall;
    logic [AW-1:0]   w_addr_c, r_addr_c;
    logic [DW-1:0]   w_data_c;
    logic            w_inr, r_inr;

    logic [DW-1:0]   mem [2**DEPTH_LOG2];

`ifdef SRAM_STALL_INJECT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // A request completing with LAT==1 commits on its capture edge, so use the live bus values then.
    assign w_addr_c = w_cap ? bus.waddr : waddr_q;
    assign w_data_c = w_cap ? bus.wdata : wdata_q;
    assign r_addr_c = r_cap ? bus.raddr : raddr_q;
    assign w_inr    = (w_addr_c[AW-1:DEPTH_LOG2] == '0);
    assign r_inr    = (r_addr_c[AW-1:DEPTH_LOG2] == '0);

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_cap     = 1'b0;
        w_commit  = 1'b0;
        w_perr    = 1'b0;
        case (w_state_q)
            IDLE, RESP: begin
                w_state_d = IDLE;
                if (bus.wvalid) begin
                    w_cap = 1'b1;
                    if (WR_LAT == 1) begin
                        w_state_d = RESP;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = WAIT;
                        w_cnt_d   = CW'(WR_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (!bus.wvalid) begin
                    w_state_d = IDLE;
                    w_perr    = 1'b1;
                end else begin
                    w_perr = (bus.waddr != waddr_q) || (bus.wdata != wdata_q);
                    if (!stall) begin
                        if (w_cnt_q == '0) begin
                            w_state_d = RESP;
                            w_commit  = 1'b1;
                        end else begin
                            w_cnt_d = w_cnt_q - 1'b1;
                        end
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_cap     = 1'b0;
        r_commit  = 1'b0;
        r_perr    = 1'b0;
        case (r_state_q)
            IDLE, RESP: begin
                r_state_d = IDLE;
                if (bus.rvalid) begin
                    r_cap = 1'b1;
                    if (RD_LAT == 1) begin
                        r_state_d = RESP;
                        r_commit  = 1'b1;
                    end else begin
                        r_state_d = WAIT;
                        r_cnt_d   = CW'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (!bus.rvalid) begin
                    r_state_d = IDLE;
                    r_perr    = 1'b1;
                end else begin
                    r_perr = (bus.raddr != raddr_q);
                    if (!stall) begin
                        if (r_cnt_q == '0) begin
                            r_state_d = RESP;
                            r_commit  = 1'b1;
                        end else begin
                            r_cnt_d = r_cnt_q - 1'b1;
                        end
                    end
                end
            end
            default: r_state_d = IDLE;
        endcase
    end

    // Write-first: a read completing on the same edge as a write to the same word sees the new data.
    always_comb begin
        rdata_d = rdata_q;
        if (r_commit) begin
            if (!r_inr)
                rdata_d = OOR_DATA;
            else if (w_commit && w_inr && (w_addr_c[DEPTH_LOG2-1:0] == r_addr_c[DEPTH_LOG2-1:0]))
                rdata_d = w_data_c;
            else
                rdata_d = mem[r_addr_c[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q   <= IDLE;
            r_state_q   <= IDLE;
            w_cnt_q     <= '0;
            r_cnt_q     <= '0;
            wready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            w_cnt_q     <= w_cnt_d;
            r_cnt_q     <= r_cnt_d;
            wready_q    <= w_commit;
            rready_q    <= r_commit;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_q | w_perr | r_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            waddr_q <= bus.waddr;
            wdata_q <= bus.wdata;
        end
        if (r_cap) raddr_q <= bus.raddr;
        if (w_commit && w_inr) mem[w_addr_c[DEPTH_LOG2-1:0]] <= w_data_c;
    end

    assign bus.wready    = wready_q;
    assign bus.rready    = rready_q;
    assign bus.rdata     = rdata_q;
    assign bus.proto_err = proto_err_q;
endmodule
